// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared state encoding, layer defaults and width helpers for the MLP layer sequencer
package mlp_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

  localparam int DEF_NUM_INPUTS  = 16;
  localparam int DEF_NUM_NEURONS = 8;
  localparam int DEF_ADDR_W      = 9;
  localparam int DEF_SRAM_LAT    = 1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mlp_valid_pipe.sv
// rtl/mlp_valid_pipe.sv - LAT-stage shift register aligning read sideband bits with returning SRAM data
module mlp_valid_pipe #(
  parameter int LAT = 1,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) stage[k] <= '0;
    end else begin
      stage[0] <= din;
      for (int k = 1; k < LAT; k++) stage[k] <= stage[k-1];
    end
  end

  assign dout = stage[LAT-1];

endmodule

// File: rtl/mlp_layer_sequencer.sv
// rtl/mlp_layer_sequencer.sv - sequences one fully-connected layer over weight/input SRAMs and a MAC datapath
// Optional MLP_BIAS_FETCH_EN adds a leading bias beat per neuron read from the weight SRAM.
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SRAM_LAT    = DEF_SRAM_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] weight_addr,
  output logic [ADDR_W-1:0] input_addr,
  output logic              mac_valid,
  output logic              mac_first,
  output logic              mac_last,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              out_ready
);

`ifdef MLP_BIAS_FETCH_EN
  localparam int BEATS = NUM_INPUTS + 1;
`else
  localparam int BEATS = NUM_INPUTS;
`endif
  localparam int IW = cnt_w(BEATS);
  localparam int NW = cnt_w(NUM_NEURONS);
  localparam int DW = cnt_w(SRAM_LAT);

  if (NUM_NEURONS * BEATS > (1 << ADDR_W)) begin : g_addr_wrap
    $warning("mlp_layer_sequencer: weight addresses exceed 2**ADDR_W and will wrap");
  end

  state_t            state, state_n;
  logic [IW-1:0]     beat;
  logic [NW-1:0]     neuron;
  logic [DW-1:0]     dcnt;
  logic [ADDR_W-1:0] waddr;
  logic              last_beat, last_neuron;

  assign last_beat   = (beat == IW'(BEATS - 1));
  assign last_neuron = (neuron == NW'(NUM_NEURONS - 1));

  always_comb begin
    state_n     = state;
    busy        = (state != IDLE);
    done        = 1'b0;
    rd_en       = 1'b0;
    out_wr_en   = 1'b0;
    weight_addr = '0;
    input_addr  = '0;
    out_addr    = '0;
    case (state)
      IDLE: if (start) state_n = ISSUE;
      ISSUE: begin
        rd_en       = 1'b1;
        weight_addr = waddr;
`ifdef MLP_BIAS_FETCH_EN
        input_addr  = (beat == '0) ? '0 : ADDR_W'(beat - IW'(1));
`else
        input_addr  = ADDR_W'(beat);
`endif
        if (last_beat) state_n = DRAIN;
      end
      DRAIN: if (dcnt == DW'(SRAM_LAT - 1)) state_n = WRITE;
      WRITE: begin
        out_wr_en = 1'b1;
        out_addr  = ADDR_W'(neuron);
        if (out_ready) state_n = last_neuron ? DONE : ISSUE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Weight address is a running counter: neuron-major layout makes it contiguous across neurons.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      beat   <= '0;
      neuron <= '0;
      dcnt   <= '0;
      waddr  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          beat   <= '0;
          neuron <= '0;
          waddr  <= '0;
        end
        ISSUE: begin
          waddr <= waddr + ADDR_W'(1);
          beat  <= last_beat ? '0 : beat + IW'(1);
          dcnt  <= '0;
        end
        DRAIN: dcnt <= dcnt + DW'(1);
        WRITE: if (out_ready && !last_neuron) neuron <= neuron + NW'(1);
        default: ;
      endcase
    end
  end

  mlp_valid_pipe #(.LAT(SRAM_LAT), .W(3)) u_valid_pipe (
    .clk   (clk),
    .reset (reset),
    .din   ({rd_en, rd_en && (beat == '0), rd_en && last_beat}),
    .dout  ({mac_valid, mac_first, mac_last})
  );

endmodule
